// File: rtl/stdp_synapse_array.sv
// Multi-channel pair-based STDP synapse bank feeding one saturated current into a LIF neuron.
// Define WEIGHT_LOAD_EN to add a direct weight write port (wr_en / wr_sel / wr_data).
module stdp_synapse_array #(
  parameter int unsigned N_PRE        = 4,
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned DECIMAL_BITS = 4,
  parameter int unsigned TRACE_MAX    = 32,
  parameter int unsigned A_PLUS       = 8,
  parameter int unsigned A_MINUS      = 4,
  parameter int unsigned W_MIN        = 8,
  parameter int unsigned W_MAX        = 127,
  parameter int unsigned W_INIT       = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       learn_en,
  input  logic [N_PRE-1:0]           pre_spike,
  input  logic                       post_spike,
  output logic signed [WIDTH-1:0]    i_syn,
  output logic                       ltp_pulse,
  output logic                       ltd_pulse,
`ifdef WEIGHT_LOAD_EN
  input  logic                       wr_en,
  input  logic [$clog2(N_PRE)-1:0]   wr_sel,
  input  logic [WIDTH-1:0]           wr_data,
`endif
  input  logic [$clog2(N_PRE)-1:0]   rd_sel,
  output logic [WIDTH-1:0]           rd_weight
);

  localparam int unsigned TW   = $clog2(TRACE_MAX + 1);
  localparam int unsigned SW   = $clog2(N_PRE);
  localparam int unsigned DW   = WIDTH + 2;
  localparam int unsigned SUMW = WIDTH + SW;
  localparam int unsigned NTAB = 2 ** SW;

  localparam logic [TW-1:0]        T_LOAD   = TW'(TRACE_MAX);
  localparam logic [TW-1:0]        T_HALF   = TW'(TRACE_MAX / 2);
  localparam logic signed [DW-1:0] DW_PLUS  = DW'(A_PLUS);
  localparam logic signed [DW-1:0] DW_HALF  = DW'(A_PLUS >> 1);
  localparam logic signed [DW-1:0] DW_MINUS = DW'(A_MINUS);
  localparam logic signed [DW-1:0] DW_WMIN  = DW'(W_MIN);
  localparam logic signed [DW-1:0] DW_WMAX  = DW'(W_MAX);
  localparam logic [SUMW-1:0]      SUM_SAT  = SUMW'(2 ** (WIDTH - 1) - 1);

  if (N_PRE < 2 || DECIMAL_BITS >= WIDTH || W_MAX > 2 ** (WIDTH - 1) - 1 ||
      W_INIT < W_MIN || W_INIT > W_MAX) begin : g_param_check
    $error("stdp_synapse_array: illegal parameter set");
  end

  logic [TW-1:0]        pre_trace      [N_PRE];
  logic [TW-1:0]        pre_trace_nxt  [N_PRE];
  logic [TW-1:0]        post_trace;
  logic [TW-1:0]        post_trace_nxt;
  logic [WIDTH-1:0]     weight         [N_PRE];
  logic [WIDTH-1:0]     weight_nxt     [N_PRE];
  logic signed [DW-1:0] dw             [N_PRE];
  logic signed [DW-1:0] w_sum          [N_PRE];
  logic [N_PRE-1:0]     ltp_hit;
  logic [N_PRE-1:0]     ltd_hit;
  logic [SUMW-1:0]      spike_sum;
  logic [WIDTH-1:0]     i_syn_nxt;

`ifdef WEIGHT_LOAD_EN
  logic [WIDTH-1:0] wr_clamped;
  assign wr_clamped = (wr_data > WIDTH'(W_MAX)) ? WIDTH'(W_MAX) :
                      (wr_data < WIDTH'(W_MIN)) ? WIDTH'(W_MIN) : wr_data;
`endif

  // Next-state for traces and weights, plus the spike-gated current sum, all from pre-edge state.
  always_comb begin
    post_trace_nxt = post_spike ? T_LOAD :
                     (post_trace != '0) ? post_trace - TW'(1) : '0;
    spike_sum = '0;
    for (int i = 0; i < N_PRE; i++) begin
      pre_trace_nxt[i] = pre_spike[i] ? T_LOAD :
                         (pre_trace[i] != '0) ? pre_trace[i] - TW'(1) : '0;
      ltp_hit[i] = learn_en & post_spike & (pre_trace[i] != '0);
      ltd_hit[i] = learn_en & pre_spike[i] & (post_trace != '0);
      dw[i] = '0;
      if (ltp_hit[i]) dw[i] = (pre_trace[i] >= T_HALF) ? DW_PLUS : DW_HALF;
      if (ltd_hit[i]) dw[i] = dw[i] - DW_MINUS;
      // Weights never exceed 2^(WIDTH-1)-1, so zero extension is exact.
      w_sum[i] = $signed({2'b00, weight[i]}) + dw[i];
      if (w_sum[i] > DW_WMAX)      weight_nxt[i] = WIDTH'(W_MAX);
      else if (w_sum[i] < DW_WMIN) weight_nxt[i] = WIDTH'(W_MIN);
      else                         weight_nxt[i] = w_sum[i][WIDTH-1:0];
`ifdef WEIGHT_LOAD_EN
      if (wr_en && (wr_sel == SW'(i))) weight_nxt[i] = wr_clamped;
`endif
      if (pre_spike[i]) spike_sum = spike_sum + SUMW'(weight[i]);
    end
    i_syn_nxt = (spike_sum > SUM_SAT) ? WIDTH'(SUM_SAT) : spike_sum[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_PRE; i++) begin
        pre_trace[i] <= '0;
        weight[i]    <= WIDTH'(W_INIT);
      end
      post_trace <= '0;
      i_syn      <= '0;
      ltp_pulse  <= 1'b0;
      ltd_pulse  <= 1'b0;
    end else begin
      for (int i = 0; i < N_PRE; i++) begin
        pre_trace[i] <= pre_trace_nxt[i];
        weight[i]    <= weight_nxt[i];
      end
      post_trace <= post_trace_nxt;
      i_syn      <= i_syn_nxt;
      ltp_pulse  <= |ltp_hit;
      ltd_pulse  <= |ltd_hit;
    end
  end

  // Readout table padded to the full select range; unused selects read zero.
  logic [WIDTH-1:0] rd_tab [NTAB];
  for (genvar j = 0; j < NTAB; j++) begin : g_rd
    if (j < N_PRE) begin : g_ch
      assign rd_tab[j] = weight[j];
    end else begin : g_pad
      assign rd_tab[j] = '0;
    end
  end
  assign rd_weight = rd_tab[rd_sel];

endmodule

// File: tb/tb_stdp_synapse_array.sv
// Randomized and directed bench for stdp_synapse_array against an integer behavioural model.
module tb_stdp_synapse_array;
  localparam int N         = 4;
  localparam int WIDTH     = 8;
  localparam int TRACE_MAX = 32;
  localparam int A_PLUS    = 8;
  localparam int A_MINUS   = 4;
  localparam int W_MIN     = 8;
  localparam int W_MAX     = 127;
  localparam int W_INIT    = 16;
  localparam int I_MAX     = 127;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    learn_en;
  logic [N-1:0]            pre_spike;
  logic                    post_spike;
  logic signed [WIDTH-1:0] i_syn;
  logic                    ltp_pulse;
  logic                    ltd_pulse;
  logic [1:0]              rd_sel;
  logic [WIDTH-1:0]        rd_weight;
`ifdef WEIGHT_LOAD_EN
  logic                    wr_en;
  logic [1:0]              wr_sel;
  logic [WIDTH-1:0]        wr_data;
`endif

  int errors = 0;
  int checks = 0;

  int m_pre_tr [N];
  int m_post_tr;
  int m_w [N];
  int m_isyn;
  int m_ltp;
  int m_ltd;

  stdp_synapse_array dut (
    .clk        (clk),
    .reset      (reset),
    .learn_en   (learn_en),
    .pre_spike  (pre_spike),
    .post_spike (post_spike),
    .i_syn      (i_syn),
    .ltp_pulse  (ltp_pulse),
    .ltd_pulse  (ltd_pulse),
`ifdef WEIGHT_LOAD_EN
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_data    (wr_data),
`endif
    .rd_sel     (rd_sel),
    .rd_weight  (rd_weight)
  );

  always #5 clk = ~clk;

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently being driven.
  task automatic model_step();
    int nw [N];
    int sum;
    int ltp;
    int ltd;
    int dw;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_pre_tr[i] = 0;
        m_w[i]      = W_INIT;
      end
      m_post_tr = 0;
      m_isyn    = 0;
      m_ltp     = 0;
      m_ltd     = 0;
      return;
    end
    sum = 0;
    ltp = 0;
    ltd = 0;
    for (int i = 0; i < N; i++) begin
      dw = 0;
      if (pre_spike[i]) sum += m_w[i];
      if (learn_en && post_spike && m_pre_tr[i] > 0) begin
        dw += (m_pre_tr[i] >= TRACE_MAX / 2) ? A_PLUS : A_PLUS / 2;
        ltp = 1;
      end
      if (learn_en && pre_spike[i] && m_post_tr > 0) begin
        dw -= A_MINUS;
        ltd = 1;
      end
      nw[i] = clampi(m_w[i] + dw, W_MIN, W_MAX);
`ifdef WEIGHT_LOAD_EN
      if (wr_en && int'(wr_sel) == i) nw[i] = clampi(int'(wr_data), W_MIN, W_MAX);
`endif
    end
    for (int i = 0; i < N; i++) begin
      m_w[i]      = nw[i];
      m_pre_tr[i] = pre_spike[i] ? TRACE_MAX : ((m_pre_tr[i] > 0) ? m_pre_tr[i] - 1 : 0);
    end
    m_post_tr = post_spike ? TRACE_MAX : ((m_post_tr > 0) ? m_post_tr - 1 : 0);
    m_isyn    = (sum > I_MAX) ? I_MAX : sum;
    m_ltp     = ltp;
    m_ltd     = ltd;
  endtask

  task automatic compare_all();
    check("i_syn", int'(i_syn), m_isyn);
    check("ltp_pulse", int'(ltp_pulse), m_ltp);
    check("ltd_pulse", int'(ltd_pulse), m_ltd);
    check("rd_weight", int'(rd_weight), (int'(rd_sel) < N) ? m_w[rd_sel] : 0);
  endtask

  task automatic step(input logic rst, input logic [N-1:0] pre, input logic post,
                      input logic learn);
    reset      = rst;
    pre_spike  = pre;
    post_spike = post;
    learn_en   = learn;
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic read_w(input int sel, input int exp, input string name);
    rd_sel = 2'(sel);
    #1;
    check(name, int'(rd_weight), exp);
    check({"model_", name}, m_w[sel], exp);
  endtask

  int exp_w2 [5] = '{12, 8, 8, 8, 8};

  initial begin
    reset      = 1'b1;
    learn_en   = 1'b0;
    pre_spike  = '0;
    post_spike = 1'b0;
    rd_sel     = '0;
`ifdef WEIGHT_LOAD_EN
    wr_en      = 1'b0;
    wr_sel     = '0;
    wr_data    = '0;
`endif
    @(negedge clk);
    step(1'b1, '0, 1'b0, 1'b0);
    step(1'b1, '0, 1'b0, 1'b0);

    // Reset values hold through idle.
    idle(10);
    for (int s = 0; s < N; s++) read_w(s, 16, $sformatf("reset_w%0d", s));
    check("reset_isyn", int'(i_syn), 0);
    check("reset_ltp", int'(ltp_pulse), 0);

    // Strong potentiation: trace 30 at the post spike.
    step(1'b0, 4'b0001, 1'b0, 1'b1);
    idle(2);
    step(1'b0, '0, 1'b1, 1'b1);
    check("ltp_full_pulse", int'(ltp_pulse), 1);
    read_w(0, 24, "ltp_full_w0");
    read_w(1, 16, "ltp_full_w1");
    read_w(3, 16, "ltp_full_w3");
    idle(1);
    check("ltp_full_pulse_end", int'(ltp_pulse), 0);

    // Weak potentiation (trace 13), then an expired trace.
    idle(40);
    step(1'b0, 4'b0010, 1'b0, 1'b1);
    idle(19);
    step(1'b0, '0, 1'b1, 1'b1);
    check("ltp_half_pulse", int'(ltp_pulse), 1);
    read_w(1, 20, "ltp_half_w1");
    idle(40);
    step(1'b0, 4'b0010, 1'b0, 1'b1);
    idle(39);
    step(1'b0, '0, 1'b1, 1'b1);
    check("ltp_gap_pulse", int'(ltp_pulse), 0);
    read_w(1, 20, "ltp_gap_w1");

    // Depression down to the W_MIN clamp, then frozen with learn_en low.
    for (int r = 0; r < 5; r++) begin
      idle(40);
      step(1'b0, '0, 1'b1, r < 4);
      idle(19);
      step(1'b0, 4'b0100, 1'b0, r < 4);
      check($sformatf("ltd_pulse_r%0d", r), int'(ltd_pulse), (r < 4) ? 1 : 0);
      read_w(2, exp_w2[r], $sformatf("ltd_w2_r%0d", r));
    end

    // Current sum of four default weights, one cycle wide.
    idle(40);
    step(1'b1, '0, 1'b0, 1'b1);
    step(1'b0, 4'b1111, 1'b0, 1'b1);
    check("isyn_sum", int'(i_syn), 64);
    idle(1);
    check("isyn_zero", int'(i_syn), 0);

`ifdef WEIGHT_LOAD_EN
    // Loaded weights saturate both in storage and in the current sum.
    wr_en = 1'b1;
    for (int s = 0; s < N; s++) begin
      wr_sel  = 2'(s);
      wr_data = (s == 0) ? 8'd200 : 8'd127;
      step(1'b0, '0, 1'b0, 1'b1);
    end
    wr_en = 1'b0;
    read_w(0, 127, "wr_clamp_w0");
    step(1'b0, 4'b1111, 1'b0, 1'b1);
    check("isyn_sat", int'(i_syn), 127);
    idle(1);
`endif

    // Coincident LTP and LTD on one channel nets +4.
    step(1'b1, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 4'b1000, 1'b0, 1'b0);
    step(1'b0, 4'b1000, 1'b1, 1'b1);
    check("both_ltp", int'(ltp_pulse), 1);
    check("both_ltd", int'(ltd_pulse), 1);
    read_w(3, 20, "both_w3");
    step(1'b0, 4'b0001, 1'b1, 1'b1);
    step(1'b1, 4'b1111, 1'b1, 1'b1);
    check("rst_isyn", int'(i_syn), 0);
    check("rst_ltp", int'(ltp_pulse), 0);
    check("rst_ltd", int'(ltd_pulse), 0);
    for (int s = 0; s < N; s++) read_w(s, 16, $sformatf("rst_w%0d", s));

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] pre;
      for (int i = 0; i < N; i++) pre[i] = ($urandom_range(0, 7) == 0);
      rd_sel = 2'($urandom_range(0, 3));
`ifdef WEIGHT_LOAD_EN
      wr_en   = ($urandom_range(0, 19) == 0);
      wr_sel  = 2'($urandom_range(0, 3));
      wr_data = 8'($urandom_range(0, 255));
`endif
      step($urandom_range(0, 299) == 0, pre, $urandom_range(0, 5) == 0,
           $urandom_range(0, 9) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
